// File: rtl/multi_irq_controller.sv
// ---------------------------------------------------------------------------
// multi_irq_controller
//
// Multi-source interrupt controller for the 16-bit pipelined RISC core.
// Latches rising edges on NUM_SRC maskable request lines, picks the lowest
// eligible index, drains fetch around jumps and immediate-carrying
// instructions, injects the two-word interrupt sequence into decode, exports
// the return PC and pulses a fetch redirect to the vector table. Further
// acceptance is blocked until the service routine retires its return.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   irq_in          request lines (rising edge sets a pending bit)
//   irq_mask        1 = source masked (kept pending, not accepted)
//   function_bits   class of fetch-stage instruction (3'b100 = has immediate)
//   iam_jmp         fetch-stage instruction is a jump
//   next_pc         PC fetch will use next (jump target one cycle later)
//   rti_done        return-from-interrupt retired (one-cycle pulse)
//   stall_fetch     hold fetch
//   inject_valid    inject_instr replaces the fetched word this cycle
//   inject_instr    injected word
//   save_pc_valid   save_pc is the return address (INJ1 cycle)
//   save_pc         return address
//   redirect_fetch  one-cycle pulse: load PC from vector table[vector_id]
//   vector_id       most recently accepted source index
//   in_service      a routine is active
//   pending         pending request register
// ---------------------------------------------------------------------------
module multi_irq_controller #(
   parameter int unsigned   NUM_SRC   = 4,
   parameter int unsigned   PC_W      = 32,
   parameter logic [15:0]   BUBBLE    = 16'h07F8,
   parameter logic [15:0]   INT_WORD1 = 16'hF480,
   parameter logic [15:0]   INT_WORD2 = 16'h8000,
   localparam int unsigned  ID_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  irq_in,
   input  logic [NUM_SRC-1:0]  irq_mask,
   input  logic [2:0]          function_bits,
   input  logic                iam_jmp,
   input  logic [PC_W-1:0]     next_pc,
   input  logic                rti_done,
   output logic                stall_fetch,
   output logic                inject_valid,
   output logic [15:0]         inject_instr,
   output logic                save_pc_valid,
   output logic [PC_W-1:0]     save_pc,
   output logic                redirect_fetch,
   output logic [ID_W-1:0]     vector_id,
   output logic                in_service,
   output logic [NUM_SRC-1:0]  pending
);

   localparam logic [2:0] FUNC_IMM = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_JMP_WAIT,
      S_STALL_IMM,
      S_BUBBLE,
      S_INJ1,
      S_INJ2,
      S_REDIRECT,
      S_SERVICE
   } state_t;

   state_t               state_q, state_d;

   logic [NUM_SRC-1:0]   irq_prev_q, irq_prev_d;
   logic [NUM_SRC-1:0]   pending_q, pending_d;
   logic [NUM_SRC-1:0]   rise;
   logic [NUM_SRC-1:0]   eligible;
   logic [NUM_SRC-1:0]   clr;

   logic [ID_W-1:0]      vector_id_q, vector_id_d;
   logic [PC_W-1:0]      save_pc_q, save_pc_d;

   logic [ID_W-1:0]      sel_id;
   logic                 sel_found;
   logic                 accept;

   logic                 stall_fetch_q, stall_fetch_d;
   logic                 inject_valid_q, inject_valid_d;
   logic [15:0]          inject_instr_q, inject_instr_d;
   logic                 save_pc_valid_q, save_pc_valid_d;
   logic                 redirect_fetch_q, redirect_fetch_d;
   logic                 in_service_q, in_service_d;

   // Edge detect on request lines; masking only gates eligibility.
   always_comb begin
      irq_prev_d = irq_in;
      rise       = irq_in & ~irq_prev_q;
      eligible   = pending_q & ~irq_mask;
   end

   // Lowest-index eligible source.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (!sel_found && eligible[i]) begin
            sel_found = 1'b1;
            sel_id    = ID_W'(i);
         end
      end
   end

   assign accept = (state_q == S_IDLE) && sel_found;

   // Acceptance clears its own bit; a coincident new edge re-sets it.
   always_comb begin
      clr       = accept ? (NUM_SRC'(1) << sel_id) : '0;
      pending_d = (pending_q & ~clr) | rise;
   end

   // Sequencer next state, vector latch and return-PC capture.
   always_comb begin
      state_d     = state_q;
      vector_id_d = vector_id_q;
      save_pc_d   = save_pc_q;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               vector_id_d = sel_id;
               if (iam_jmp) begin
                  state_d = S_JMP_WAIT;
               end else if (function_bits == FUNC_IMM) begin
                  // Return past the immediate word that still has to reach decode.
                  state_d   = S_STALL_IMM;
                  save_pc_d = next_pc + PC_W'(1);
               end else begin
                  state_d   = S_BUBBLE;
                  save_pc_d = next_pc;
               end
            end
         end
         S_JMP_WAIT: begin
            // Jump target resolves on next_pc one cycle after acceptance.
            save_pc_d = next_pc;
            state_d   = S_INJ1;
         end
         S_STALL_IMM: state_d = S_BUBBLE;
         S_BUBBLE:    state_d = S_INJ1;
         S_INJ1:      state_d = S_INJ2;
         S_INJ2:      state_d = S_REDIRECT;
         S_REDIRECT:  state_d = S_SERVICE;
         S_SERVICE: begin
            if (rti_done) begin
               state_d = S_IDLE;
            end
         end
         default:     state_d = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the next state so they register with it.
   always_comb begin
      stall_fetch_d    = 1'b0;
      inject_valid_d   = 1'b0;
      inject_instr_d   = '0;
      save_pc_valid_d  = 1'b0;
      redirect_fetch_d = 1'b0;
      in_service_d     = 1'b0;
      case (state_d)
         S_JMP_WAIT,
         S_STALL_IMM: begin
            stall_fetch_d = 1'b1;
         end
         S_BUBBLE: begin
            stall_fetch_d  = 1'b1;
            inject_valid_d = 1'b1;
            inject_instr_d = BUBBLE;
         end
         S_INJ1: begin
            stall_fetch_d   = 1'b1;
            inject_valid_d  = 1'b1;
            inject_instr_d  = INT_WORD1;
            save_pc_valid_d = 1'b1;
         end
         S_INJ2: begin
            stall_fetch_d  = 1'b1;
            inject_valid_d = 1'b1;
            inject_instr_d = INT_WORD2 | 16'(vector_id_d);
         end
         S_REDIRECT: begin
            redirect_fetch_d = 1'b1;
         end
         S_SERVICE: begin
            in_service_d = 1'b1;
         end
         default: begin
            stall_fetch_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= S_IDLE;
         irq_prev_q       <= '0;
         pending_q        <= '0;
         vector_id_q      <= '0;
         save_pc_q        <= '0;
         stall_fetch_q    <= 1'b0;
         inject_valid_q   <= 1'b0;
         inject_instr_q   <= '0;
         save_pc_valid_q  <= 1'b0;
         redirect_fetch_q <= 1'b0;
         in_service_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         irq_prev_q       <= irq_prev_d;
         pending_q        <= pending_d;
         vector_id_q      <= vector_id_d;
         save_pc_q        <= save_pc_d;
         stall_fetch_q    <= stall_fetch_d;
         inject_valid_q   <= inject_valid_d;
         inject_instr_q   <= inject_instr_d;
         save_pc_valid_q  <= save_pc_valid_d;
         redirect_fetch_q <= redirect_fetch_d;
         in_service_q     <= in_service_d;
      end
   end

   assign stall_fetch    = stall_fetch_q;
   assign inject_valid   = inject_valid_q;
   assign inject_instr   = inject_instr_q;
   assign save_pc_valid  = save_pc_valid_q;
   assign save_pc        = save_pc_q;
   assign redirect_fetch = redirect_fetch_q;
   assign vector_id      = vector_id_q;
   assign in_service     = in_service_q;
   assign pending        = pending_q;

endmodule

// File: tb/tb_multi_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_multi_irq_controller
//
// Directed scenarios followed by a randomized run. Every cycle the outputs
// are compared against a reference model that, on acceptance, schedules the
// whole per-cycle output script for the interrupt entry sequence.
// ---------------------------------------------------------------------------
module tb_multi_irq_controller;

   localparam int unsigned NS  = 4;
   localparam int unsigned PW  = 32;
   localparam int unsigned IDW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NS-1:0]   irq_in;
   logic [NS-1:0]   irq_mask;
   logic [2:0]      function_bits;
   logic            iam_jmp;
   logic [PW-1:0]   next_pc;
   logic            rti_done;
   logic            stall_fetch;
   logic            inject_valid;
   logic [15:0]     inject_instr;
   logic            save_pc_valid;
   logic [PW-1:0]   save_pc;
   logic            redirect_fetch;
   logic [IDW-1:0]  vector_id;
   logic            in_service;
   logic [NS-1:0]   pending;

   multi_irq_controller #(.NUM_SRC(NS), .PC_W(PW)) dut (
      .clk            (clk),
      .rst            (rst),
      .irq_in         (irq_in),
      .irq_mask       (irq_mask),
      .function_bits  (function_bits),
      .iam_jmp        (iam_jmp),
      .next_pc        (next_pc),
      .rti_done       (rti_done),
      .stall_fetch    (stall_fetch),
      .inject_valid   (inject_valid),
      .inject_instr   (inject_instr),
      .save_pc_valid  (save_pc_valid),
      .save_pc        (save_pc),
      .redirect_fetch (redirect_fetch),
      .vector_id      (vector_id),
      .in_service     (in_service),
      .pending        (pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        stall;
      logic        inj;
      logic [15:0] instr;
      logic        spv;
      logic        redir;
      logic        svc;
      logic        jw;     // leaving this cycle captures the jump target
   } ent_t;

   ent_t          cur;
   ent_t          script[$];
   logic [NS-1:0] m_pend;
   logic [NS-1:0] m_prev;
   logic [IDW-1:0] m_vec;
   logic [PW-1:0] m_save;

   function automatic ent_t mk(input logic s, input logic i, input logic [15:0] w,
                               input logic p, input logic r, input logic v, input logic j);
      ent_t e;
      e.stall = s; e.inj = i; e.instr = w; e.spv = p; e.redir = r; e.svc = v; e.jw = j;
      return e;
   endfunction

   task automatic model_reset();
      cur = '0;
      script.delete();
      m_pend = '0;
      m_prev = '0;
      m_vec  = '0;
      m_save = '0;
   endtask

   // Advance the model across one rising edge using the inputs now applied.
   task automatic model_step();
      logic [NS-1:0] rise, clr, elig;
      int k;
      rise = irq_in & ~m_prev;
      clr  = '0;
      if (cur.svc) begin
         if (rti_done) cur = '0;
      end else if (script.size() != 0) begin
         if (cur.jw) m_save = next_pc;
         cur = script.pop_front();
      end else begin
         elig = m_pend & ~irq_mask;
         k = -1;
         for (int i = 0; i < NS; i++) if (k < 0 && elig[i]) k = i;
         if (k >= 0) begin
            clr   = NS'(1) << k;
            m_vec = IDW'(k);
            if (iam_jmp) begin
               script.push_back(mk(1, 0, 16'h0, 0, 0, 0, 1));
            end else if (function_bits == 3'b100) begin
               script.push_back(mk(1, 0, 16'h0, 0, 0, 0, 0));
               script.push_back(mk(1, 1, 16'h07F8, 0, 0, 0, 0));
               m_save = next_pc + 32'd1;
            end else begin
               script.push_back(mk(1, 1, 16'h07F8, 0, 0, 0, 0));
               m_save = next_pc;
            end
            script.push_back(mk(1, 1, 16'hF480, 1, 0, 0, 0));
            script.push_back(mk(1, 1, 16'h8000 + 16'(k), 0, 0, 0, 0));
            script.push_back(mk(0, 0, 16'h0, 0, 1, 0, 0));
            script.push_back(mk(0, 0, 16'h0, 0, 0, 1, 0));
            cur = script.pop_front();
         end
      end
      m_pend = (m_pend & ~clr) | rise;
      m_prev = irq_in;
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, ".stall"},  32'(stall_fetch),    32'(cur.stall));
      check_eq({tag, ".injv"},   32'(inject_valid),   32'(cur.inj));
      if (cur.inj) check_eq({tag, ".instr"}, 32'(inject_instr), 32'(cur.instr));
      check_eq({tag, ".spv"},    32'(save_pc_valid),  32'(cur.spv));
      if (cur.spv) check_eq({tag, ".save_pc"}, save_pc, m_save);
      check_eq({tag, ".redir"},  32'(redirect_fetch), 32'(cur.redir));
      check_eq({tag, ".insvc"},  32'(in_service),     32'(cur.svc));
      check_eq({tag, ".vec"},    32'(vector_id),      32'(m_vec));
      check_eq({tag, ".pend"},   32'(pending),        32'(m_pend));
   endtask

   task automatic tick(input string tag);
      if (!rst) model_step();
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic rti_pulse(input string tag);
      rti_done = 1'b1;
      tick(tag);
      rti_done = 1'b0;
   endtask

   // Asynchronous reset applied between edges, held across one edge.
   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs({tag, ".async"});
      @(posedge clk);
      #1;
      check_outputs({tag, ".held"});
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; irq_in = '0; irq_mask = '0; function_bits = '0;
      iam_jmp = 1'b0; next_pc = '0; rti_done = 1'b0;
      model_reset();
      #2;
      check_outputs("reset");
      check_eq("reset.pend", 32'(pending), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick("idle");

      // Plain case: source 2, no immediate, no jump.
      next_pc = 32'h40; irq_in = 4'b0100;
      tick("plain.e0");  check_eq("plain.pend_set", 32'(pending), 32'h4);
      tick("plain.e1");  check_eq("plain.bubble", 32'(inject_instr), 32'h07F8);
                         check_eq("plain.vec", 32'(vector_id), 32'd2);
                         check_eq("plain.pend_clr", 32'(pending), 32'h0);
      tick("plain.e2");  check_eq("plain.w1", 32'(inject_instr), 32'hF480);
                         check_eq("plain.save_pc", save_pc, 32'h40);
      tick("plain.e3");  check_eq("plain.w2", 32'(inject_instr), 32'h8002);
      tick("plain.e4");  check_eq("plain.redir", 32'(redirect_fetch), 32'd1);
                         check_eq("plain.nostall", 32'(stall_fetch), 32'd0);
      tick("plain.e5");  check_eq("plain.svc", 32'(in_service), 32'd1);
      rti_pulse("plain.rti"); check_eq("plain.rti", 32'(in_service), 32'd0);
      irq_in = '0; tick("gap");

      // Immediate case: source 0, one extra non-injecting stall.
      function_bits = 3'b100; next_pc = 32'h40; irq_in = 4'b0001;
      tick("imm.e0");
      tick("imm.e1");    check_eq("imm.stall", 32'(stall_fetch), 32'd1);
                         check_eq("imm.noinj", 32'(inject_valid), 32'd0);
      tick("imm.e2");    check_eq("imm.bubble", 32'(inject_instr), 32'h07F8);
      tick("imm.e3");    check_eq("imm.save_pc", save_pc, 32'h41);
      tick("imm.e4");    check_eq("imm.w2", 32'(inject_instr), 32'h8000);
      tick("imm.e5");    check_eq("imm.redir", 32'(redirect_fetch), 32'd1);
      tick("imm.svc");
      rti_pulse("imm.rti");
      function_bits = '0; irq_in = '0; tick("gap");

      // Jump case: source 1, target appears one cycle after acceptance.
      iam_jmp = 1'b1; next_pc = 32'h80; irq_in = 4'b0010;
      tick("jmp.e0");
      tick("jmp.e1");    check_eq("jmp.noinj", 32'(inject_valid), 32'd0);
      next_pc = 32'h120; iam_jmp = 1'b0;
      tick("jmp.e2");    check_eq("jmp.w1", 32'(inject_instr), 32'hF480);
                         check_eq("jmp.save_pc", save_pc, 32'h120);
      tick("jmp.e3");    check_eq("jmp.w2", 32'(inject_instr), 32'h8001);
      tick("jmp.e4");    check_eq("jmp.redir", 32'(redirect_fetch), 32'd1);
      tick("jmp.svc");
      rti_pulse("jmp.rti");
      irq_in = '0; tick("gap");

      // Priority and mask: sources 1 and 3 together, 1 masked.
      irq_mask = 4'b0010; irq_in = 4'b1010;
      tick("pm.e0");     check_eq("pm.pend", 32'(pending), 32'hA);
      tick("pm.e1");     check_eq("pm.vec3", 32'(vector_id), 32'd3);
                         check_eq("pm.keep1", 32'(pending), 32'h2);
      repeat (4) tick("pm.seq");
      irq_mask = '0;
      rti_pulse("pm.rti"); check_eq("pm.idle_noinj", 32'(inject_valid), 32'd0);
                           check_eq("pm.still1", 32'(pending), 32'h2);
      tick("pm.acc1");   check_eq("pm.vec1", 32'(vector_id), 32'd1);
      repeat (4) tick("pm.seq1");

      // Blocking: new edge on source 0 while source 1 is in service.
      irq_in = 4'b1011;
      tick("blk.edge");  check_eq("blk.pend0", 32'(pending), 32'h1);
      repeat (3) begin
         tick("blk.wait"); check_eq("blk.noinj", 32'(inject_valid), 32'd0);
      end
      rti_pulse("blk.rti"); check_eq("blk.rti_noinj", 32'(inject_valid), 32'd0);
      tick("blk.acc");   check_eq("blk.vec0", 32'(vector_id), 32'd0);
                         check_eq("blk.inj", 32'(inject_valid), 32'd1);
      repeat (4) tick("blk.seq");
      rti_pulse("blk.rti2");
      irq_in = '0; tick("gap");

      // Reset in the middle of INJ1, then a fresh full sequence.
      irq_in = 4'b0100; next_pc = 32'h44;
      tick("rs.e0"); tick("rs.e1");
      tick("rs.e2");     check_eq("rs.inj1", 32'(save_pc_valid), 32'd1);
      irq_in = '0;
      apply_reset("rs");
      check_eq("rs.stall0", 32'(stall_fetch), 32'd0);
      check_eq("rs.save0", save_pc, 32'h0);
      check_eq("rs.pend0", 32'(pending), 32'h0);
      tick("rs.idle");
      irq_in = 4'b0100; next_pc = 32'h200;
      tick("rs2.e0"); tick("rs2.e1");
      tick("rs2.e2");    check_eq("rs2.save_pc", save_pc, 32'h200);
      tick("rs2.e3");    check_eq("rs2.w2", 32'(inject_instr), 32'h8002);
      tick("rs2.e4");    check_eq("rs2.redir", 32'(redirect_fetch), 32'd1);
      tick("rs2.svc");
      rti_pulse("rs2.rti");

      // Randomized run against the model.
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < NS; b++) if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
         if ($urandom_range(15) == 0) irq_mask = NS'($urandom);
         function_bits = 3'($urandom);
         iam_jmp       = ($urandom_range(3) == 0);
         next_pc       = $urandom;
         rti_done      = ($urandom_range(5) == 0);
         if ($urandom_range(399) == 0) apply_reset("rnd.rst");
         else tick("rnd");
      end
      rti_done = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
